// File: rtl/alu_mul_seq_if.sv
// Launch/complete handshake and operand/result bus of the sequential Booth multiplier.
// The master launches multiplies; the slave (the multiplier) returns the split product.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one recoding step per clock.
// Product is published as hi/lo halves on the edge of the final step and held until the next one.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_mul_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   a_reg, a_next, a_sum;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             qm1_reg, qm1_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             launch, last_step;

    assign launch    = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_step = (state_reg == ST_RUN) && (cnt_reg == CW'(WIDTH - 1));

    // Booth step: A is one bit wider than the operands so +/-M never overflows.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_next   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next   = {a_sum[0], q_reg[WIDTH-1:1]};
        qm1_next = q_reg[0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            qm1_reg   <= 1'b0;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                m_reg   <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                q_reg   <= bus.multiplier;
                a_reg   <= '0;
                qm1_reg <= 1'b0;
                cnt_reg <= '0;
            end else if (state_reg == ST_RUN) begin
                a_reg   <= a_next;
                q_reg   <= q_next;
                qm1_reg <= qm1_next;
                cnt_reg <= cnt_reg + 1'b1;
            end
            // The sign lives in A, so its low WIDTH bits are the upper product half.
            if (last_step) begin
                hi_reg <= a_next[WIDTH-1:0];
                lo_reg <= q_next;
            end
        end
    end

    assign bus.busy       = (state_reg == ST_RUN);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.product_hi = hi_reg;
    assign bus.product_lo = lo_reg;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed sign/extreme/handshake/reset cases plus
// randomized operands against a plain 64-bit signed multiply reference.
module tb_alu_mul_seq;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [2*W-1:0] prev_exp;

    alu_mul_seq_if #(.WIDTH(W)) bus ();

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return 64'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] prod();
        return {bus.product_hi, bus.product_lo};
    endfunction

    // One full multiply; optionally re-asserts start with junk operands mid-run.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                          input string tag);
        logic [2*W-1:0] exp;
        int lat;
        int bcnt;
        bit unstable;
        exp = model(a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom;
        lat = 0; unstable = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= W + 8; i++) begin
            if (poke && i == 4) begin
                bus.start = 1'b1; bus.multiplicand = $urandom; bus.multiplier = $urandom;
            end else if (poke && i == 8) begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) bcnt++;
            if (prod() !== prev_exp) unstable = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(W));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_product"}, prod(), exp);
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        $display("txn %s: %h x %h -> %h_%h (lat %0d)", tag, a, b, bus.product_hi,
                 bus.product_lo, lat);
        prev_exp = exp;
        @(posedge clk); #1;
        check({tag, "_done_single"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] specials [5];
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] ex, ey;
        int lat1, lat2;

        n_cmp = 0; n_err = 0; prev_exp = '0;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        rst_n = 1'b0;
        specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", prod(), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        do_mul(32'd6, 32'd7, 1'b0, "basic_6x7");
        do_mul(32'hFFFF_FFFD, 32'd5, 1'b0, "neg3x5");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "neg1xneg1");
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b0, "min_x_min");
        check("min_x_min_const", prod(), 64'h4000_0000_0000_0000);
        do_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "max_x_min");
        check("max_x_min_const", prod(), 64'hC000_0000_8000_0000);
        do_mul(32'h0012_3456, 32'hFFF0_1234, 1'b1, "start_in_run");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_product", prod(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(bus.done), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        prev_exp = '0;
        do_mul(32'd3, 32'd4, 1'b0, "after_rst_3x4");
        check("after_rst_lo", 64'(bus.product_lo), 64'd12);

        // start held high across DONE: back-to-back launch.
        ex = model(32'd1234, 32'hFFFF_F000);
        ey = model(32'hDEAD_BEEF, 32'h0BAD_F00D);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd1234; bus.multiplier = 32'hFFFF_F000;
        @(posedge clk); #1;
        bus.multiplicand = 32'hDEAD_BEEF; bus.multiplier = 32'h0BAD_F00D;
        lat1 = 0;
        for (int i = 1; i <= W + 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat1 = i; break; end
        end
        check("b2b_lat1", 64'(lat1), 64'(W));
        check("b2b_prod1", prod(), ex);
        lat2 = 0;
        for (int i = 1; i <= W + 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.start = 1'b0;
                check("b2b_done_single", 64'(bus.done), 64'd0);
                check("b2b_relaunch_busy", 64'(bus.busy), 64'd1);
            end
            if (bus.done) begin lat2 = i; break; end
        end
        check("b2b_spacing", 64'(lat2), 64'(W + 1));
        check("b2b_prod2", prod(), ey);
        $display("txn b2b: %h then %h spacing %0d", ex, ey, lat2);
        prev_exp = ey;
        @(posedge clk); #1;
        check("b2b_idle", 64'(bus.busy | bus.done), 64'd0);

        for (int n = 0; n < 1000; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
            do_mul(ra, rb, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequential signed multiplier; the multiply counterpart of the ALU's combinational divide path.
- Computes a signed WIDTH x WIDTH product using radix-2 Booth recoding, one recoding step per clock.
- Presents the 2*WIDTH result as hi/lo halves for the CPU's HI/LO registers.
- The datapath launches it with a start/done handshake, so the control unit can stall for a known, fixed number of cycles.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled at rising clk edges
- multiplicand  input  WIDTH  signed two's-complement operand A
- multiplier  input  WIDTH  signed two's-complement operand B
- busy  output  1  high while a multiply is in progress (RUN state)
- done  output  1  one-cycle pulse; product valid
- product_hi  output  WIDTH  upper half of the signed product
- product_lo  output  WIDTH  lower half of the signed product

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset, effective immediately (no clock needed):
  - state=IDLE, busy=0, done=0
  - product_hi=0, product_lo=0
  - internal accumulator, multiplier shift register, Booth bit q_-1 and step counter all cleared.
- States:
  - IDLE -> RUN on a clk edge with start=1.
  - RUN -> RUN while the step counter < WIDTH-1; RUN -> DONE on the edge that performs step WIDTH-1.
  - DONE -> RUN if start=1 (back-to-back accepted); DONE -> IDLE otherwise.
- Launch edge (start accepted in IDLE or DONE):
  - Latch multiplicand into M, a WIDTH+1 bit sign-extended register.
  - Latch multiplier into Q.
  - Set A=0 (WIDTH+1 bits), q_-1=0, counter=0.
  - busy=1 from the next cycle.
  - Operand inputs are don't-care after the launch edge.
- Each RUN edge, inspect {Q[0], q_-1}:
  - 01: A=A+M
  - 10: A=A-M
  - 00/11: no change
  - Then arithmetic-shift {A,Q,q_-1} right by 1, with A's MSB replicated. Counter increments.
- Arithmetic rules:
  - A is WIDTH+1 bits, so the most-negative multiplicand (-2^(WIDTH-1)) and its negation never overflow.
  - Final product = {A[WIDTH-1:0], Q}; the sign is carried through A.
- Completion:
  - The edge performing step WIDTH-1 (the WIDTH-th step) loads product_hi/product_lo and sets done=1, busy=0.
  - Latency: done is high in the cycle following the WIDTH-th edge after the launch edge (32 edges when WIDTH=32).
- done is high exactly one cycle. product_hi/lo hold their value until the next completion or reset; they do not change during a subsequent RUN.
- start while in RUN is ignored, with no effect on the operation in flight.
- start held high continuously: one multiply per WIDTH+1 cycles (launch in DONE).
- Reset asserted mid-RUN aborts the operation, leaving no done pulse and outputs cleared. After reset deassertion the block is in IDLE and accepts start on the next edge.
- No overflow flag: the full 2*WIDTH product is always exact.

Test Plan:
- Reset mid-operation: launch 7 x 9, pull rst_n low at step 10 -> busy=0, done=0, product=0 asynchronously. Release rst_n, then launch 3 x 4 -> product_lo=12, done after the normal latency.
- Basic and latency check: rst_n low then high; start with 6 x 7 -> busy high for 32 cycles; done pulses one cycle after the 32nd RUN edge; product_hi=0x00000000, product_lo=0x0000002A.
- Signs:
  - -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1
  - -1 x -1 -> hi=0x00000000, lo=0x00000001
- Extremes:
  - 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000
  - 0x7FFFFFFF x 0x80000000 -> hi=0xC0000000, lo=0x80000000
- Handshake:
  - Assert start again during RUN with different operands -> ignored; the first result is delivered unchanged.
  - Start held high across DONE -> second multiply launches on the DONE edge. done pulses are exactly 33 cycles apart, each a single cycle.
- Random regression: 1000 random signed operand pairs, including 0 and ±1 -> {product_hi,product_lo} equals the 64-bit signed reference product. Outputs remain stable between done pulses.
